// File: rtl/lut_stream_pkg.sv
// -----------------------------------------------------------------------------
// lut_stream_pkg
// Shared defaults for the LUT stream reader slice:
//   LUT_ADDR_WIDTH  - ROM address width
//   LUT_DATA_WIDTH  - ROM data width
//   LUT_ROM_LATENCY - cycles from ROM address capture to valid rd_data (1..2)
//   LUT_FIFO_DEPTH  - output buffer entries (power of two, >= latency + 2)
// and the {last, data} buffer entry layout for the default data width.
// -----------------------------------------------------------------------------
package lut_stream_pkg;

    localparam int LUT_ADDR_WIDTH  = 10;
    localparam int LUT_DATA_WIDTH  = 8;
    localparam int LUT_ROM_LATENCY = 1;
    localparam int LUT_FIFO_DEPTH  = 4;

    typedef struct packed {
        logic                      last;
        logic [LUT_DATA_WIDTH-1:0] data;
    } lut_entry_t;

endpackage

// File: rtl/lut_stream_reader_if.sv
// -----------------------------------------------------------------------------
// lut_stream_reader_if
// Bundles the request stream, the LUT ROM port and the result stream of
// lut_stream_reader.
//   s_valid/s_ready/s_addr/s_last : lookup request stream
//   rom_addr/rom_data             : LUT ROM address out / read data in
//   m_valid/m_ready/m_data/m_last : lookup result stream
// Modports:
//   slave  - the reader itself
//   master - the surrounding environment (request source, ROM, result sink)
// -----------------------------------------------------------------------------
interface lut_stream_reader_if
    import lut_stream_pkg::*;
#(
    parameter int ADDR_WIDTH = LUT_ADDR_WIDTH,
    parameter int DATA_WIDTH = LUT_DATA_WIDTH
);

    logic                  s_valid;
    logic                  s_ready;
    logic [ADDR_WIDTH-1:0] s_addr;
    logic                  s_last;

    logic [ADDR_WIDTH-1:0] rom_addr;
    logic [DATA_WIDTH-1:0] rom_data;

    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_last;

    modport slave (
        input  s_valid, s_addr, s_last, rom_data, m_ready,
        output s_ready, rom_addr, m_valid, m_data, m_last
    );

    modport master (
        output s_valid, s_addr, s_last, rom_data, m_ready,
        input  s_ready, rom_addr, m_valid, m_data, m_last
    );

endinterface

// File: rtl/lut_stream_fifo.sv
// -----------------------------------------------------------------------------
// lut_stream_fifo
// Synchronous first-word-fall-through buffer with an occupancy count.
//   clk, rst  : clock, synchronous active-high reset (pointers/count only)
//   wr_en     : push wr_entry (caller guarantees the buffer is not full)
//   wr_entry  : entry to push
//   rd_en     : pop the head entry (ignored while empty)
//   rd_entry  : head entry, all-zero while empty
//   count     : number of stored entries (0..DEPTH)
//   empty     : count == 0
// DEPTH must be a power of two so the pointers wrap by plain overflow.
// -----------------------------------------------------------------------------
module lut_stream_fifo
    import lut_stream_pkg::*;
#(
    parameter int  DEPTH   = LUT_FIFO_DEPTH,
    parameter type entry_t = lut_entry_t
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  entry_t                 wr_entry,
    input  logic                   rd_en,
    output entry_t                 rd_entry,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty
);

    localparam int PTR_W = $clog2(DEPTH);

    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_rd;

    assign empty = (count_q == '0);
    assign count = count_q;
    assign do_rd = rd_en && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_rd) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        // Simultaneous push and pop leaves the occupancy unchanged.
        case ({wr_en, do_rd})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is data only; it is never reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

    // Zero the head while empty so stale entries never show on the output.
    always_comb begin
        rd_entry = '0;
        if (!empty) begin
            rd_entry = mem_q[rd_ptr_q];
        end
    end

endmodule

// File: rtl/lut_stream_reader.sv
// -----------------------------------------------------------------------------
// lut_stream_reader
// Turns a stream of LUT indices into a stream of looked-up values from an
// external LUT ROM with ROM_LATENCY cycles of read latency, preserving order
// and the per-request last tag, with full-rate throughput and backpressure.
//   clk       : single rising-edge clock
//   rst       : synchronous active-high reset
//   bus       : lut_stream_reader_if.slave (request stream, ROM port, results)
//   frame_cnt : (only with LUT_STREAM_CNT_EN) 16-bit count of delivered
//               results carrying last, wraps 0xFFFF -> 0
// Optional feature macro: LUT_STREAM_CNT_EN adds frame_cnt.
//
// Flow control is credit based: a request is only accepted when the output
// buffer is guaranteed a slot for it, counting both buffered results and
// requests still inside the ROM latency pipeline.
// -----------------------------------------------------------------------------
module lut_stream_reader
    import lut_stream_pkg::*;
#(
    parameter int ADDR_WIDTH  = LUT_ADDR_WIDTH,
    parameter int DATA_WIDTH  = LUT_DATA_WIDTH,
    parameter int ROM_LATENCY = LUT_ROM_LATENCY,
    parameter int FIFO_DEPTH  = LUT_FIFO_DEPTH
) (
    input  logic               clk,
    input  logic               rst,
`ifdef LUT_STREAM_CNT_EN
    output logic [15:0]        frame_cnt,
`endif
    lut_stream_reader_if.slave bus
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        logic                  last;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    logic [ADDR_WIDTH-1:0]  req_addr;
    logic                   accept;
    logic                   exit_vld;
    logic                   pop;
    logic [ROM_LATENCY-1:0] vld_q, vld_d;
    logic [ROM_LATENCY-1:0] last_q, last_d;
    logic [CNT_W-1:0]       inflight_q, inflight_d;
    logic [CNT_W-1:0]       fifo_count;
    logic [CNT_W:0]         credit_used;
    logic                   fifo_empty;
    entry_t                 wr_entry;
    entry_t                 rd_entry;

    // The ROM sees every address; reads that are not accepted are harmless.
    assign req_addr     = bus.s_addr;
    assign bus.rom_addr = req_addr;

    // Registered counts only, so s_ready never depends on m_ready/s_valid.
    assign credit_used = {1'b0, fifo_count} + {1'b0, inflight_q};
    assign bus.s_ready = !rst && (credit_used < (CNT_W+1)'(FIFO_DEPTH));

    assign accept   = bus.s_valid && bus.s_ready;
    assign exit_vld = vld_q[ROM_LATENCY-1];
    assign pop      = bus.m_valid && bus.m_ready;

    always_comb begin
        vld_d     = '0;
        last_d    = '0;
        vld_d[0]  = accept;
        last_d[0] = bus.s_last;
        for (int i = 1; i < ROM_LATENCY; i++) begin
            vld_d[i]  = vld_q[i-1];
            last_d[i] = last_q[i-1];
        end
        inflight_d = inflight_q + CNT_W'(accept) - CNT_W'(exit_vld);
        // rom_data lines up with the request leaving the last stage.
        wr_entry.last = last_q[ROM_LATENCY-1];
        wr_entry.data = bus.rom_data;
    end

    // ---- ROM latency pipeline: valid bits and in-flight count ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q      <= '0;
            inflight_q <= '0;
        end else begin
            vld_q      <= vld_d;
            inflight_q <= inflight_d;
        end
    end

    // last tags only matter where the matching valid bit is set.
    always_ff @(posedge clk) begin
        last_q <= last_d;
    end

    // ---- output buffer ----
    lut_stream_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (exit_vld),
        .wr_entry (wr_entry),
        .rd_en    (pop),
        .rd_entry (rd_entry),
        .count    (fifo_count),
        .empty    (fifo_empty)
    );

    assign bus.m_valid = !fifo_empty;
    assign bus.m_data  = rd_entry.data;
    assign bus.m_last  = rd_entry.last;

`ifdef LUT_STREAM_CNT_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (pop && rd_entry.last) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_lut_stream_reader.sv
// -----------------------------------------------------------------------------
// tb_lut_stream_reader
// Self-checking bench for lut_stream_reader with a behavioural LUT ROM
// (rom[i] = i[7:0] ^ 8'h5A, configurable latency) and a queue-based model of
// outstanding requests. Honours LUT_STREAM_CNT_EN (adds frame_cnt checks and
// runs the ROM with latency 2).
// -----------------------------------------------------------------------------
module tb_lut_stream_reader;

    localparam int AW    = 10;
    localparam int DW    = 8;
    localparam int DEPTH = 4;
`ifdef LUT_STREAM_CNT_EN
    localparam int ROM_LAT = 2;
`else
    localparam int ROM_LAT = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lut_stream_reader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

`ifdef LUT_STREAM_CNT_EN
    logic [15:0] frame_cnt;
`endif

    lut_stream_reader #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .ROM_LATENCY (ROM_LAT),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef LUT_STREAM_CNT_EN
        .frame_cnt (frame_cnt),
`endif
        .bus       (bus)
    );

    // ---------------- behavioural ROM ----------------
    logic [DW-1:0] rom_mem  [1 << AW];
    logic [DW-1:0] rom_pipe [ROM_LAT];

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            rom_mem[i] = DW'(i) ^ 8'h5A;
        end
    end

    always @(posedge clk) begin
        rom_pipe[0] <= rom_mem[bus.rom_addr];
        for (int i = 1; i < ROM_LAT; i++) begin
            rom_pipe[i] <= rom_pipe[i-1];
        end
    end

    assign bus.rom_data = rom_pipe[ROM_LAT-1];

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Each accepted request is visible at the output from its acceptance
    // cycle + ROM_LAT + 1 onwards, in acceptance order; outstanding requests
    // (accepted, not yet delivered) may never exceed DEPTH.
    typedef struct {
        int unsigned   acc;
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    exp_t        mq[$];
    int unsigned cyc = 0;
    bit          mon_en = 1'b0;
    int          pop_cnt = 0;
    logic        last_pop_last = 1'b0;
    logic [15:0] frames_model = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mon_en) begin
            logic exp_sready;
            logic exp_mvalid;
            exp_t e;
            exp_sready = !rst && (mq.size() < DEPTH);
            exp_mvalid = (mq.size() > 0) && (cyc >= mq[0].acc + ROM_LAT + 1);
            check_eq("s_ready", 32'(bus.s_ready), 32'(exp_sready));
            check_eq("m_valid", 32'(bus.m_valid), 32'(exp_mvalid));
            if (exp_mvalid && bus.m_valid) begin
                check_eq("m_data", 32'(bus.m_data), 32'(mq[0].data));
                check_eq("m_last", 32'(bus.m_last), 32'(mq[0].last));
            end
`ifdef LUT_STREAM_CNT_EN
            check_eq("frame_cnt", 32'(frame_cnt), 32'(frames_model));
`endif
            if (rst) begin
                mq.delete();
                frames_model = '0;
            end else begin
                if (exp_mvalid && bus.m_ready) begin
                    e = mq.pop_front();
                    pop_cnt++;
                    last_pop_last = e.last;
                    if (e.last) frames_model = frames_model + 16'd1;
                end
                if (bus.s_valid && exp_sready) begin
                    e.acc  = cyc;
                    e.data = bus.s_addr[DW-1:0] ^ 8'h5A;
                    e.last = bus.s_last;
                    mq.push_back(e);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    int stall_cnt = 0;
    bit rand_mready = 1'b0;

    always @(posedge clk) begin
        #1;
        if (rand_mready) bus.m_ready = 1'($urandom_range(0, 1));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one request and hold it until accepted (bounded).
    task automatic send(input int a, input logic l);
        bit done;
        int n;
        done = 1'b0;
        n    = 0;
        bus.s_valid = 1'b1;
        bus.s_addr  = AW'(a);
        bus.s_last  = l;
        while (!done) begin
            @(negedge clk);
            done = bus.s_ready;
            if (!done) stall_cnt++;
            step();
            n++;
            if (!done && n > 200) begin
                check_eq("send_timeout", 32'd0, 32'd1);
                done = 1'b1;
            end
        end
        bus.s_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 400 && mq.size() != 0; k++) @(negedge clk);
        check_eq("drain_empty", 32'(mq.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        int c;
        int lat;
        int acc;
        int k;
        int p0;
        int seen;

        bus.s_valid = 1'b0;
        bus.s_addr  = '0;
        bus.s_last  = 1'b0;
        bus.m_ready = 1'b0;

        // Reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_s_ready", 32'(bus.s_ready), 32'd0);
        step();
        rst    = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        check_eq("rel_s_ready", 32'(bus.s_ready), 32'd1);
        check_eq("rel_m_valid", 32'(bus.m_valid), 32'd0);
        check_eq("rel_m_data", 32'(bus.m_data), 32'd0);
        check_eq("rel_m_last", 32'(bus.m_last), 32'd0);

        // Single lookup, latency
        step();
        bus.m_ready = 1'b1;
        bus.s_valid = 1'b1;
        bus.s_addr  = 10'h003;
        bus.s_last  = 1'b1;
        @(negedge clk);
        c = int'(cyc);
        check_eq("single_accept", 32'(bus.s_ready), 32'd1);
        step();
        bus.s_valid = 1'b0;
        lat = -1;
        for (int i = 0; i < 10 && lat < 0; i++) begin
            @(negedge clk);
            if (bus.m_valid) begin
                lat = int'(cyc) - c;
                check_eq("single_data", 32'(bus.m_data), 32'h59);
                check_eq("single_last", 32'(bus.m_last), 32'd1);
            end
        end
        check_eq("single_latency", 32'(lat), 32'(ROM_LAT + 1));
        drain();

        // Full-rate stream 0..1023
        step();
        p0 = pop_cnt;
        stall_cnt = 0;
        bus.m_ready = 1'b1;
        for (int i = 0; i < 1024; i++) send(i, i == 1023);
        check_eq("stream_stalls", 32'(stall_cnt), 32'd0);
        drain();
        check_eq("stream_count", 32'(pop_cnt - p0), 32'd1024);
        check_eq("stream_final_last", 32'(last_pop_last), 32'd1);

        // Backpressure
        step();
        p0 = pop_cnt;
        bus.m_ready = 1'b0;
        k   = 0;
        acc = 0;
        for (int i = 0; i < 12; i++) begin
            bus.s_valid = 1'b1;
            bus.s_addr  = AW'(k);
            bus.s_last  = 1'b0;
            @(negedge clk);
            if (bus.s_ready) begin
                k++;
                acc++;
            end
            step();
        end
        bus.s_valid = 1'b0;
        check_eq("bp_accepts", 32'(acc), 32'(DEPTH));
        @(negedge clk);
        check_eq("bp_hold_valid", 32'(bus.m_valid), 32'd1);
        check_eq("bp_hold_data", 32'(bus.m_data), 32'h5A);
        step();
        bus.m_ready = 1'b1;
        for (; k < 12; k++) send(k, k == 11);
        drain();
        check_eq("bp_count", 32'(pop_cnt - p0), 32'd12);
        check_eq("bp_final_last", 32'(last_pop_last), 32'd1);

        // Reset with three results buffered
        step();
        bus.m_ready = 1'b0;
        send(100, 1'b0);
        send(101, 1'b0);
        send(102, 1'b1);
        repeat (ROM_LAT + 1) step();
        @(negedge clk);
        check_eq("pre_rst_valid", 32'(bus.m_valid), 32'd1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check_eq("post_rst_valid", 32'(bus.m_valid), 32'd0);
        check_eq("post_rst_ready", 32'(bus.s_ready), 32'd1);
        check_eq("post_rst_data", 32'(bus.m_data), 32'd0);
        step();
        bus.m_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.m_valid) seen++;
        end
        check_eq("post_rst_stale", 32'(seen), 32'd0);

        // Randomized traffic
        step();
        for (int i = 0; i < 1500; i++) begin
            bus.s_valid = ($urandom_range(0, 3) != 0);
            bus.s_addr  = AW'($urandom);
            bus.s_last  = ($urandom_range(0, 7) == 0);
            bus.m_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b1;
        drain();

`ifdef LUT_STREAM_CNT_EN
        // Three frames of eight with random downstream readiness
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        rand_mready = 1'b1;
        for (int f = 0; f < 3; f++) begin
            for (int j = 0; j < 8; j++) send(f * 8 + j, j == 7);
        end
        rand_mready = 1'b0;
        step();
        bus.m_ready = 1'b1;
        drain();
        @(negedge clk);
        check_eq("frame_cnt_final", 32'(frame_cnt), 32'd3);
`endif

        step();
        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/lut_stream_reader.md
LUT_STREAM_READER -- requirements
Module: lut_stream_reader

Interface
REQ-001 Parameter ADDR_WIDTH, 10: ROM address width; SHALL match the attached LUT ROM.
REQ-002 Parameter DATA_WIDTH, 8: ROM data width; SHALL match the attached LUT ROM.
REQ-003 Parameter ROM_LATENCY, 1: clock cycles from ROM address capture to valid rom_data; legal 1..2.
REQ-004 Parameter FIFO_DEPTH, 4: output buffer entries; SHALL be at least ROM_LATENCY+2 and a power of two.
REQ-005 Port clk, in, 1: the single clock; all logic SHALL be rising-edge clk.
REQ-006 Port rst, in, 1: reset, synchronous and active-high.
REQ-007 Port s_valid, in, 1: upstream lookup request valid.
REQ-008 Port s_ready, out, 1: request accepted when s_valid && s_ready.
REQ-009 Port s_addr, in, ADDR_WIDTH: lookup index.
REQ-010 Port s_last, in, 1: end-of-frame tag carried alongside the request.
REQ-011 Port rom_addr, out, ADDR_WIDTH: drives the LUT ROM addr port.
REQ-012 Port rom_data, in, DATA_WIDTH: LUT ROM rd_data.
REQ-013 Port m_valid, out, 1: result valid.
REQ-014 Port m_ready, in, 1: downstream accepts when m_valid && m_ready.
REQ-015 Port m_data, out, DATA_WIDTH: looked-up value.
REQ-016 Port m_last, out, 1: s_last of the originating request.

Function
REQ-017 rom_addr SHALL equal s_addr combinationally every cycle; reads without acceptance are harmless and ignored.
REQ-018 An accepted request SHALL enter a ROM_LATENCY-stage valid/last shift pipeline; on exit, rom_data and last SHALL be written to the FIFO on that edge.
REQ-019 Latency: a request accepted in cycle c SHALL produce m_valid in cycle c+ROM_LATENCY+1 when the FIFO is empty and the stream is unstalled.
REQ-020 Credit rule: s_ready = (fifo_count + inflight) < FIFO_DEPTH, computed from registered counts only; s_ready SHALL NOT depend combinationally on m_ready or s_valid.
REQ-021 Throughput: with m_ready held high, one result per cycle SHALL be sustained indefinitely.
REQ-022 Order: results SHALL emerge in acceptance order; m_data/m_last SHALL remain stable while m_valid && !m_ready.
REQ-023 A simultaneous FIFO write and pop SHALL leave fifo_count unchanged; a slot freed by a pop SHALL raise s_ready in the next cycle.
REQ-024 The FIFO SHALL never overflow; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-025 m_valid SHALL be high exactly when fifo_count != 0.

Reset
REQ-026 While rst=1 at a clk edge: pipeline valid bits, FIFO pointers, fifo_count and inflight SHALL clear to 0.
REQ-027 Output reset values: s_ready=0 during rst, 1 on the first cycle after release; m_valid=0; m_data=0; m_last=0.
REQ-028 Reset mid-operation SHALL discard all in-flight and buffered results; no stale result SHALL appear after release.

Configuration
REQ-029 Macro LUT_STREAM_CNT_EN: when defined, SHALL add output port frame_cnt (16 bits, reset 0), incremented on each m_valid && m_ready && m_last and wrapping 0xFFFF->0.
REQ-030 Without LUT_STREAM_CNT_EN, frame_cnt and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-031 Package lut_stream_pkg SHALL hold default ADDR_WIDTH, DATA_WIDTH, ROM_LATENCY and FIFO_DEPTH constants, plus the {last, data} entry struct typedef.
REQ-032 The buffer SHALL be a sub-module lut_stream_fifo, synchronous, first-word-fall-through, with count output. Everything else stays in lut_stream_reader.

Verification
REQ-033 Bench SHALL use a behavioural ROM model with configurable latency and contents rom[i]=i[7:0]^8'h5A.
REQ-034 Single lookup: s_addr=10'h003 accepted in cycle 0, m_ready=1 -> m_valid in cycle 2, m_data=8'h59, m_last as driven.
REQ-035 Streaming: addresses 0..1023 back-to-back, m_ready=1 -> 1024 results in order, one per cycle, final m_last=1, s_ready never low.
REQ-036 Backpressure: m_ready=0 while streaming -> s_ready falls after exactly 4 accepts, m_data holds 8'h5A; raise m_ready -> remaining data in order, none lost or duplicated.
REQ-037 Reset mid-stream: assert rst for 1 cycle with 3 results buffered -> m_valid=0 next cycle, s_ready=1 after release, no stale output.
REQ-038 With LUT_STREAM_CNT_EN and ROM_LATENCY=2: three frames of 8 lookups with random m_ready -> frame_cnt=3, latency check c+3 holds.
